// File: rtl/freelist_pkg.sv
// -----------------------------------------------------------------------------
// freelist_pkg
// Shared sizing constants, ROB state codes and small helpers for the physical
// register free list.
//   PREG_SIZE / LREG_SIZE : physical / architectural register counts
//   FL_DEPTH              : free-list queue entries (PREG_SIZE - LREG_SIZE)
//   FL_PTR_W / FL_IDX_W   : pointer width (index + wrap bit) / index width
//   rob_state_e           : ROB recovery state seen by the free list
// -----------------------------------------------------------------------------
package freelist_pkg;

    localparam int PREG_SIZE = 64;
    localparam int LREG_SIZE = 32;
    localparam int FL_DEPTH  = PREG_SIZE - LREG_SIZE;

    localparam int PREG_W    = $clog2(PREG_SIZE);   // 6
    localparam int FL_IDX_W  = $clog2(FL_DEPTH);    // 5
    localparam int FL_PTR_W  = FL_IDX_W + 1;        // index plus wrap bit

    typedef enum logic [1:0] {
        ROB_STATE_IDLE          = 2'd0,
        ROB_STATE_OVERWRITE_RAT = 2'd1,
        ROB_STATE_WALKING       = 2'd2
    } rob_state_e;

    // Number of asserted bits in a two-lane request pair.
    function automatic logic [1:0] pair_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/freelist_ptr_adv.sv
// -----------------------------------------------------------------------------
// fl_ptr_adv
// Free-list pointer register: advances by 0, 1 or 2 per cycle, or loads an
// absolute value. Synchronous active-low reset to RST_VAL.
//   clock, reset_n : clock and synchronous active-low reset
//   load, load_val : absolute load (takes priority over inc)
//   inc            : advance amount 0..2
//   ptr            : current pointer value
//   ptr_next       : value the pointer takes at the next edge
// -----------------------------------------------------------------------------
module fl_ptr_adv #(
    parameter int               PTR_W   = 6,
    parameter logic [PTR_W-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    input  logic [1:0]       inc,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] ptr_next
);

    logic [PTR_W-1:0] ptr_reg;

    always_comb begin
        ptr_next = ptr_reg + PTR_W'(inc);
        if (load) begin
            ptr_next = load_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_reg <= RST_VAL;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/freelist.sv
// -----------------------------------------------------------------------------
// freelist
// Physical-register free list for rename/dispatch. Offers two free pregs per
// cycle, takes back pregs released at commit, and recovers its speculative
// head on ROB redirect (restore to the architectural head, then replay the
// surviving allocations during the walk).
//   clock, reset_n            : clock, synchronous active-low reset
//   alloc_req0/1              : rename slots consuming the offered pregs
//   alloc_prd0/1              : pregs offered to slot 0 / slot 1
//   alloc_ready               : both offers valid and allocation permitted
//   commit_en0/1              : committed instructions that wrote an rd
//   release_en0/1, addr0/1    : old pregs returned at commit
//   rob_state                 : IDLE / OVERWRITE_RAT / WALKING
//   rob_walk0/1_valid         : walk entries re-allocating a preg
//   free_count                : tail - spec_head
// -----------------------------------------------------------------------------
module freelist
    import freelist_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alloc_req0,
    input  logic              alloc_req1,
    output logic [PREG_W-1:0] alloc_prd0,
    output logic [PREG_W-1:0] alloc_prd1,
    output logic              alloc_ready,
    input  logic              commit_en0,
    input  logic              commit_en1,
    input  logic              release_en0,
    input  logic [PREG_W-1:0] release_addr0,
    input  logic              release_en1,
    input  logic [PREG_W-1:0] release_addr1,
    input  logic [1:0]        rob_state,
    input  logic              rob_walk0_valid,
    input  logic              rob_walk1_valid,
    output logic [PREG_W-1:0] free_count
);

    localparam logic [FL_PTR_W-1:0] TAIL_RST = FL_PTR_W'(FL_DEPTH);

    logic [PREG_W-1:0]   entry_reg [FL_DEPTH];

    logic [FL_PTR_W-1:0] spec_head, spec_head_next;
    logic [FL_PTR_W-1:0] arch_head, arch_head_next;
    logic [FL_PTR_W-1:0] tail, tail_next;

    logic [1:0]          alloc_cnt, commit_cnt, release_cnt, walk_cnt;
    logic [1:0]          spec_inc;
    logic                spec_load;
    logic                is_idle;

    logic [FL_IDX_W-1:0] rd_idx0, rd_idx1;
    logic [FL_IDX_W-1:0] wr_idx_a, wr_idx_b;
    logic                wr_en_a, wr_en_b;
    logic [PREG_W-1:0]   wr_data_a, wr_data_b;

    assign alloc_cnt   = pair_count(alloc_req0, alloc_req1);
    assign commit_cnt  = pair_count(commit_en0, commit_en1);
    assign release_cnt = pair_count(release_en0, release_en1);
    assign walk_cnt    = pair_count(rob_walk0_valid, rob_walk1_valid);

    // ---------------------------------------------------------------- offers
    assign is_idle     = (rob_state == ROB_STATE_IDLE);
    assign free_count  = tail - spec_head;
    assign alloc_ready = is_idle && (free_count >= PREG_W'(2));

    assign rd_idx0     = spec_head[FL_IDX_W-1:0];
    assign rd_idx1     = rd_idx0 + FL_IDX_W'(1);
    assign alloc_prd0  = entry_reg[rd_idx0];
    assign alloc_prd1  = entry_reg[rd_idx1];

    // ------------------------------------------------- speculative head control
    // Allocation counts only whole requests: rename packs slot requests so a
    // lone slot-1 request simply consumes alloc_prd0.
    always_comb begin
        spec_inc  = 2'd0;
        spec_load = 1'b0;
        case (rob_state)
            ROB_STATE_IDLE:          spec_inc  = alloc_ready ? alloc_cnt : 2'd0;
            ROB_STATE_OVERWRITE_RAT: spec_load = 1'b1;
            ROB_STATE_WALKING:       spec_inc  = walk_cnt;
            default:                 spec_inc  = 2'd0;
        endcase
    end

    // Restore lands on the architectural head including this cycle's commits.
    fl_ptr_adv #(.PTR_W(FL_PTR_W), .RST_VAL('0)) u_spec_head (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (spec_load),
        .load_val (arch_head_next),
        .inc      (spec_inc),
        .ptr      (spec_head),
        .ptr_next (spec_head_next)
    );

    fl_ptr_adv #(.PTR_W(FL_PTR_W), .RST_VAL('0)) u_arch_head (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (1'b0),
        .load_val ('0),
        .inc      (commit_cnt),
        .ptr      (arch_head),
        .ptr_next (arch_head_next)
    );

    fl_ptr_adv #(.PTR_W(FL_PTR_W), .RST_VAL(TAIL_RST)) u_tail (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (1'b0),
        .load_val ('0),
        .inc      (release_cnt),
        .ptr      (tail),
        .ptr_next (tail_next)
    );

    // ------------------------------------------------------------ release write
    // Releases are packed onto consecutive slots starting at tail, so a lone
    // release_en1 still lands at tail.
    assign wr_idx_a  = tail[FL_IDX_W-1:0];
    assign wr_idx_b  = wr_idx_a + FL_IDX_W'(1);
    assign wr_en_a   = release_en0 || release_en1;
    assign wr_en_b   = release_en0 && release_en1;
    assign wr_data_a = release_en0 ? release_addr0 : release_addr1;
    assign wr_data_b = release_addr1;

    // Each entry resets to its own preg number so the list starts holding
    // pregs LREG_SIZE .. PREG_SIZE-1.
    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                entry_reg[gi] <= PREG_W'(LREG_SIZE + gi);
            end else if (wr_en_a && (wr_idx_a == FL_IDX_W'(gi))) begin
                entry_reg[gi] <= wr_data_a;
            end else if (wr_en_b && (wr_idx_b == FL_IDX_W'(gi))) begin
                entry_reg[gi] <= wr_data_b;
            end
        end
    end

    // ------------------------------------------------------- usage assertions
    // Live region is arch_head..tail; it may never exceed the queue depth.
    a_release_full : assert property (@(posedge clock) disable iff (!reset_n)
        (FL_PTR_W'(tail_next - arch_head_next) <= FL_PTR_W'(FL_DEPTH)));

    // Allocation or walk must stay behind tail.
    a_spec_past_tail : assert property (@(posedge clock) disable iff (!reset_n)
        (FL_PTR_W'(spec_inc) <= free_count));

    // Commits cannot retire pregs that were never handed out.
    a_commit_past_spec : assert property (@(posedge clock) disable iff (!reset_n)
        (FL_PTR_W'(commit_cnt) <= FL_PTR_W'(spec_head - arch_head)));

    // After the update spec_head must still lie within arch_head..tail.
    a_spec_window : assert property (@(posedge clock) disable iff (!reset_n)
        (FL_PTR_W'(spec_head_next - arch_head_next) <=
         FL_PTR_W'(tail_next - arch_head_next)));

endmodule

// File: tb/tb_freelist.sv
// -----------------------------------------------------------------------------
// tb_freelist
// Directed scenarios followed by legal random traffic, checked every cycle
// against a reference model that keeps unbounded integer counters for the
// heads and tail and a plain array of queue contents.
// -----------------------------------------------------------------------------
module tb_freelist;
    import freelist_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       alloc_req0, alloc_req1;
    logic [5:0] alloc_prd0, alloc_prd1;
    logic       alloc_ready;
    logic       commit_en0, commit_en1;
    logic       release_en0, release_en1;
    logic [5:0] release_addr0, release_addr1;
    logic [1:0] rob_state;
    logic       rob_walk0_valid, rob_walk1_valid;
    logic [5:0] free_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: counters never wrap; queue slot = counter mod depth.
    int m_mem [FL_DEPTH];
    int m_spec, m_arch, m_tail;

    always #5 clock = ~clock;

    freelist dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .alloc_req0      (alloc_req0),
        .alloc_req1      (alloc_req1),
        .alloc_prd0      (alloc_prd0),
        .alloc_prd1      (alloc_prd1),
        .alloc_ready     (alloc_ready),
        .commit_en0      (commit_en0),
        .commit_en1      (commit_en1),
        .release_en0     (release_en0),
        .release_addr0   (release_addr0),
        .release_en1     (release_en1),
        .release_addr1   (release_addr1),
        .rob_state       (rob_state),
        .rob_walk0_valid (rob_walk0_valid),
        .rob_walk1_valid (rob_walk1_valid),
        .free_count      (free_count)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FL_DEPTH; i++) m_mem[i] = LREG_SIZE + i;
        m_spec = 0;
        m_arch = 0;
        m_tail = FL_DEPTH;
    endtask

    // Apply one clock edge of behaviour using the inputs present at the edge.
    task automatic model_edge();
        int  fc, t, arch_n;
        bit  rdy;
        if (!reset_n) begin
            model_reset();
            return;
        end
        fc  = m_tail - m_spec;
        rdy = (rob_state == ROB_STATE_IDLE) && (fc >= 2);
        arch_n = m_arch + int'(commit_en0) + int'(commit_en1);
        t = m_tail;
        if (release_en0) begin m_mem[t % FL_DEPTH] = int'(release_addr0); t++; end
        if (release_en1) begin m_mem[t % FL_DEPTH] = int'(release_addr1); t++; end
        m_tail = t;
        if (rob_state == ROB_STATE_IDLE) begin
            if (rdy) m_spec += int'(alloc_req0) + int'(alloc_req1);
        end else if (rob_state == ROB_STATE_OVERWRITE_RAT) begin
            m_spec = arch_n;
        end else if (rob_state == ROB_STATE_WALKING) begin
            m_spec += int'(rob_walk0_valid) + int'(rob_walk1_valid);
        end
        m_arch = arch_n;
    endtask

    task automatic idle_inputs();
        alloc_req0 = 0; alloc_req1 = 0;
        commit_en0 = 0; commit_en1 = 0;
        release_en0 = 0; release_en1 = 0;
        release_addr0 = '0; release_addr1 = '0;
        rob_state = ROB_STATE_IDLE;
        rob_walk0_valid = 0; rob_walk1_valid = 0;
    endtask

    // One transaction: clock edge, model update, compare outputs 1 time unit later.
    task automatic cycle();
        int exp_fc;
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        exp_fc = m_tail - m_spec;
        $display("cyc=%0d rst_n=%0b st=%0d req=%0b%0b cmt=%0b%0b rel=%0b%0b walk=%0b%0b -> prd0=%0d prd1=%0d rdy=%0b fc=%0d",
                 cyc, reset_n, rob_state, alloc_req0, alloc_req1, commit_en0, commit_en1,
                 release_en0, release_en1, rob_walk0_valid, rob_walk1_valid,
                 alloc_prd0, alloc_prd1, alloc_ready, free_count);
        check_eq("prd0", int'(alloc_prd0), m_mem[m_spec % FL_DEPTH]);
        check_eq("prd1", int'(alloc_prd1), m_mem[(m_spec + 1) % FL_DEPTH]);
        check_eq("free_count", int'(free_count), exp_fc);
        check_eq("ready", int'(alloc_ready),
                 ((rob_state == ROB_STATE_IDLE) && (exp_fc >= 2)) ? 1 : 0);
    endtask

    task automatic alloc_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            idle_inputs();
            alloc_req0 = 1; alloc_req1 = 1;
            cycle();
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        cycle();
        reset_n = 1;
    endtask

    initial begin
        int avail, room, fc, r;
        model_reset();
        idle_inputs();
        reset_n = 0;
        cycle();
        cycle();
        check_eq("rst_prd0", int'(alloc_prd0), 32);
        check_eq("rst_prd1", int'(alloc_prd1), 33);
        check_eq("rst_fc", int'(free_count), 32);
        check_eq("rst_ready", int'(alloc_ready), 1);
        reset_n = 1;

        // Three dual allocations.
        for (int k = 0; k < 3; k++) begin
            alloc_cycles(1);
            check_eq("t1_prd0", int'(alloc_prd0), 34 + 2 * k);
            check_eq("t1_prd1", int'(alloc_prd1), 35 + 2 * k);
        end
        check_eq("t1_fc", int'(free_count), 26);

        // Drain to empty; further requests are ignored.
        alloc_cycles(13);
        check_eq("t2_empty_fc", int'(free_count), 0);
        check_eq("t2_empty_ready", int'(alloc_ready), 0);
        alloc_cycles(1);
        check_eq("t2_ignored_fc", int'(free_count), 0);
        idle_inputs();
        commit_en0 = 1; commit_en1 = 1;
        release_en0 = 1; release_addr0 = 6'd40;
        release_en1 = 1; release_addr1 = 6'd41;
        cycle();
        check_eq("t2_rel_prd0", int'(alloc_prd0), 40);
        check_eq("t2_rel_prd1", int'(alloc_prd1), 41);
        check_eq("t2_rel_ready", int'(alloc_ready), 1);

        // Redirect: restore then walk.
        do_reset();
        alloc_cycles(3);
        idle_inputs();
        commit_en0 = 1; commit_en1 = 1;
        cycle();
        idle_inputs();
        rob_state = ROB_STATE_OVERWRITE_RAT;
        cycle();
        check_eq("t3_ovr_prd0", int'(alloc_prd0), 34);
        check_eq("t3_ovr_fc", int'(free_count), 30);
        idle_inputs();
        rob_state = ROB_STATE_WALKING;
        rob_walk0_valid = 1; rob_walk1_valid = 1;
        alloc_req0 = 1; alloc_req1 = 1;
        cycle();
        check_eq("t3_walk_prd0", int'(alloc_prd0), 36);
        check_eq("t3_walk_fc", int'(free_count), 28);

        // Wrap: steady alloc/commit/release pushes tail past the last index.
        do_reset();
        alloc_cycles(1);
        for (int k = 0; k < 20; k++) begin
            idle_inputs();
            alloc_req0 = 1; alloc_req1 = 1;
            commit_en0 = 1; commit_en1 = 1;
            release_en0 = 1; release_addr0 = 6'(2 * k + 1);
            release_en1 = 1; release_addr1 = 6'(2 * k + 2);
            cycle();
            check_eq("t4_wrap_fc", int'(free_count), 30);
        end
        idle_inputs();
        commit_en0 = 1; commit_en1 = 1;
        release_en0 = 1; release_addr0 = 6'd50;
        release_en1 = 1; release_addr1 = 6'd51;
        cycle();
        check_eq("t4_final_fc", int'(free_count), 32);

        // Reset while walking with a release pending.
        alloc_cycles(2);
        idle_inputs();
        rob_state = ROB_STATE_WALKING;
        rob_walk0_valid = 1;
        commit_en0 = 1;
        release_en0 = 1; release_addr0 = 6'd7;
        reset_n = 0;
        cycle();
        idle_inputs();
        reset_n = 1;
        #1;
        check_eq("t5_prd0", int'(alloc_prd0), 32);
        check_eq("t5_fc", int'(free_count), 32);
        check_eq("t5_ready", int'(alloc_ready), 1);

        // Random legal traffic.
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            reset_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            r = int'($urandom_range(0, 9));
            if (r == 0)      rob_state = ROB_STATE_OVERWRITE_RAT;
            else if (r == 1) rob_state = ROB_STATE_WALKING;
            else             rob_state = ROB_STATE_IDLE;
            alloc_req0 = 1'($urandom_range(0, 3) != 0);
            alloc_req1 = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1))
                                                     : (alloc_req0 & 1'($urandom_range(0, 1)));
            fc = m_tail - m_spec;
            rob_walk0_valid = 1'($urandom_range(0, 1)) & (fc >= 1);
            rob_walk1_valid = rob_walk0_valid & 1'($urandom_range(0, 1)) & (fc >= 2);
            avail = m_spec - m_arch;
            commit_en0 = 1'($urandom_range(0, 1)) & (avail >= 1);
            commit_en1 = 1'($urandom_range(0, 1)) & (avail >= int'(commit_en0) + 1);
            room = FL_DEPTH - (m_tail - m_arch) + int'(commit_en0) + int'(commit_en1);
            release_en0 = 1'($urandom_range(0, 1)) & (room >= 1);
            release_en1 = 1'($urandom_range(0, 1)) & (room >= int'(release_en0) + 1);
            release_addr0 = 6'($urandom_range(0, 63));
            release_addr1 = 6'($urandom_range(0, 63));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
